// File: rtl/seq_mult.sv
// seq_mult: sequential shift-add multiplier with an unsigned or two's-complement operand mode.
// Ports: clk, rst (async, active-high); in_valid/in_ready + a, b, signed_mode (operand handshake);
//        out_valid/out_ready + product (result handshake); busy (high while computing or holding).
// Latency: W edges from accept to out_valid. One result per W+2 cycles. Result held until out_ready.
module seq_mult #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0]   ONE_W  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0] ONE_2W = {{(2*W-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  LAST_C = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic           neg_q, neg_d;

  logic [W-1:0]   a_mag, b_mag;
  logic [2*W-1:0] partial, acc_sum;

  // Operand magnitudes. Negating the most negative value wraps back to the
  // same bit pattern, which read as unsigned is exactly 2^(W-1), so no
  // special case is needed.
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (signed_mode && a[W-1]) a_mag = (~a) + ONE_W;
    if (signed_mode && b[W-1]) b_mag = (~b) + ONE_W;
  end

  // One multiplier bit per cycle, LSB first.
  always_comb begin
    partial = {{W{1'b0}}, mcand_q} << cnt_q;
    acc_sum = acc_q;
    if (mplier_q[cnt_q]) acc_sum = acc_q + partial;
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = signed_mode & (a[W-1] ^ b[W-1]);
          cnt_d    = '0;
          acc_d    = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + ONE_C;
        if (cnt_q == LAST_C) begin
          // Final bit: the sum including this cycle's add is the magnitude.
          prod_d  = neg_q ? ((~acc_sum) + ONE_2W) : acc_sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Returning to IDLE takes this edge; a new accept waits for the next one.
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign product   = prod_q;

endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 The module SHALL have parameter W, default 8, setting the operand width; legal range 2..16.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The module SHALL have port in_valid, input, 1, meaning the operand set is presented.
REQ-005 The module SHALL have port in_ready, output, 1, meaning the block can accept operands.
REQ-006 The module SHALL have port a, input, W, the multiplicand.
REQ-007 The module SHALL have port b, input, W, the multiplier.
REQ-008 The module SHALL have port signed_mode, input, 1: 1 = two's-complement operands, 0 = unsigned.
REQ-009 The module SHALL have port out_valid, output, 1, meaning product holds a completed result.
REQ-010 The module SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 The module SHALL have port product, output, 2W, the result.
REQ-012 The module SHALL have port busy, output, 1, high in CALC and DONE.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and DONE; in_ready = (state == IDLE), combinational from state only.
REQ-014 Accept SHALL occur on an edge with in_valid && in_ready: a, b and signed_mode are registered, the bit counter is cleared, the accumulator is cleared, and the state goes to CALC.
REQ-015 In signed mode, accept SHALL store the magnitudes of a and b plus a negate flag equal to a[W-1] XOR b[W-1]; in unsigned mode the operands SHALL be stored raw with negate = 0.
REQ-016 Each CALC cycle SHALL process one multiplier bit, LSB first: if the current bit = 1, add the multiplicand shifted left by the counter into the 2W-bit accumulator; then increment the counter.
REQ-017 After W CALC cycles the state SHALL go to DONE, with product = accumulator, or its 2W-bit two's-complement negation when negate = 1; out_valid SHALL rise exactly W rising edges after the accept edge.
REQ-018 Magnitude of -2^(W-1) SHALL be taken as the unsigned value 2^(W-1), with no overflow; the result SHALL always fit in 2W bits with no saturation.
REQ-019 In DONE, out_valid = 1 and product SHALL be held stable until an edge with out_ready = 1; that edge SHALL return the state to IDLE.
REQ-020 out_valid SHALL be low in IDLE and CALC; product SHALL retain its last value outside DONE.
REQ-021 in_valid, a, b and signed_mode SHALL be ignored while busy = 1; there is no accept in the same cycle as a DONE->IDLE transition.
REQ-022 Throughput SHALL be one result per W+2 cycles when in_valid and out_ready are held high.

Reset
REQ-023 Assertion of rst SHALL immediately force: state IDLE, in_ready 1, out_valid 0, busy 0, product 0, counter 0, accumulator 0, negate 0.
REQ-024 rst asserted mid-CALC or in DONE SHALL discard the operation; no out_valid SHALL follow.
REQ-025 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification (W=8 unless noted)
REQ-026 Unsigned 255 x 255 with out_ready = 1 -> out_valid exactly 8 edges after accept, product = 16'hFE01, then in_ready back to 1.
REQ-027 Signed: -3 x 5 -> 16'hFFF1; -128 x -128 -> 16'h4000; -128 x 127 -> 16'hC080; 0 x -1 -> 16'h0000.
REQ-028 Backpressure: out_ready = 0 for 5 cycles in DONE -> out_valid and product held constant and in_ready = 0 throughout; release -> IDLE next edge.
REQ-029 Operand changes and in_valid pulses during CALC -> ignored; the result matches the originally accepted operands.
REQ-030 rst pulse at CALC cycle 3 -> all outputs at reset values immediately, no out_valid; the next accept of 12 x 10 -> 16'h0078.
REQ-031 Run a randomised sweep at W=4 (all 256 operand pairs x both modes) and W=16 against a reference model, with random in_valid/out_ready gaps -> zero mismatches.
